fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Single-clock synchronous FIFO: buffers DATA_WIDTH-bit words in order of arrival.
- Producer writes with wr_en; consumer reads with rd_en.
- Provides full/empty status for flow control.
- Generic storage block for datapath buffering between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits.
- FIFO_DEPTH, 16, number of entries; any value >= 2, power of two not required.
- PTR_WIDTH (derived, localparam), ceil(log2(FIFO_DEPTH)), width of the read and write pointers.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request; data_in is sampled at the rising edge.
- rd_en  input  1  read request; oldest word is moved to data_out at the rising edge.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when count == FIFO_DEPTH.
- empty  output  1  high when count == 0.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Internal registers are named write_pointer [PTR_WIDTH-1:0], read_pointer [PTR_WIDTH-1:0] and count [PTR_WIDTH:0]. The verification bench probes these names hierarchically; they are mandatory.
- Reset, asynchronous assert: write_pointer=0, read_pointer=0, count=0, data_out=0, so empty=1 and full=0. Storage array contents are not reset.
- Reset release: normal operation starts at the first rising edge after deassertion.
- Reset asserted mid-operation: all queued data is discarded immediately.
- Write accept: wr_en && !full at a rising edge.
  - mem[write_pointer] <= data_in.
  - write_pointer advances by 1, wrapping from FIFO_DEPTH-1 to 0.
- Read accept: rd_en && !empty at a rising edge.
  - data_out <= mem[read_pointer].
  - read_pointer advances by 1 with the same wrap rule.
  - Latency: data_out is valid after the edge that accepts the read (one cycle).
- data_out holds its last value when no read is accepted.
- count update per edge:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both or neither are accepted.
- full and empty are combinational decodes of count; no registered lag.
- Overflow: wr_en while full is ignored; no state change and no error flag.
- Underflow: rd_en while empty is ignored; data_out holds, no state change.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both are performed; count is unchanged.
  - Empty: only the write is performed (no read-through bypass); count becomes 1 and data_out holds.
  - Full: only the read is performed; count becomes FIFO_DEPTH-1.
- Pointers wrap independently. Full/empty are never derived from pointer equality; count is authoritative.

Decomposition:
- No shared package is needed; parameters are local to the module.
- PTR_WIDTH is computed by a local ceiling-log2 function (or $clog2).
- The storage array may optionally be split into a sub-module fifo_mem: DATA_WIDTH x FIFO_DEPTH, one write port, one synchronous read port. Control and pointer logic stay in fifo.

Test Plan:
- Reset with reset=1 for 20 ns -> empty=1, full=0, count=0, write_pointer=0, read_pointer=0, data_out=00.
- Write 0x01..0x10 on 16 consecutive cycles after reset:
  - count steps 1..16; full=1 after the 16th write and empty=0.
  - A 17th write (0x11) is ignored: count stays 16 and write_pointer stays 0.
- Read 16 times from full:
  - data_out = 01, 02, ..., 10 in order, each one cycle after the read edge.
  - empty=1 after the last read; a further rd_en leaves data_out=10 and count=0.
- Wrap-around: write 10 words, read 10, then write and read 10 more.
  - Pointers wrap past 15 to 0; data order is preserved.
  - Final read_pointer = write_pointer = 4.
- Simultaneous wr_en=rd_en=1, data_in=AA:
  - When empty: count goes 0->1, empty drops, data_out unchanged.
  - When holding 5 entries: count stays 5 and the oldest word appears on data_out.
  - When full: count goes 16->15 and AA is not stored.
- Reset asserted mid-stream with 7 entries -> count, pointers and data_out clear immediately without waiting for clk; empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo block: pointer-width calculation.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package fifo_pkg;

    // Ceiling log2, used to size pointers for any depth >= 2 (power of two not required).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo: one write port, one registered read port.
// Latency: rd_dat_o updates at the edge where rd_en_i is sampled high (1 cycle).
// Backpressure: none; the caller only asserts the enables for accepted operations.
//
// Ports:
//   clk_i, rst_i            clock and async active-high reset (read register only)
//   wr_en_i/wr_addr_i/wr_dat_i   write port
//   rd_en_i/rd_addr_i       read request; rd_dat_o holds when rd_en_i is low
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_dat_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_dat_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_dat_q;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_dat_q <= '0;
        end else if (rd_en_i) begin
            rd_dat_q <= mem[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/fifo.sv
// Single-clock synchronous FIFO buffering DATA_WIDTH-bit words in arrival order.
// Latency: data_out valid one cycle after the edge that accepts a read; no read-through when empty.
// Backpressure: writes ignored while full, reads ignored while empty; full/empty decode count directly.
//
// Ports:
//   clk, reset          clock and async active-high reset
//   wr_en, data_in      write request and data
//   rd_en, data_out     read request and registered read data (holds when no read accepted)
//   full, empty         status flags, combinational from count
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int                   PTR_WIDTH  = clog2(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR   = PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(FIFO_DEPTH);

    logic [PTR_WIDTH-1:0] write_pointer;
    logic [PTR_WIDTH-1:0] read_pointer;
    logic [PTR_WIDTH:0]   count;
    logic                 wr_accept;
    logic                 rd_accept;

    // count is the sole source of truth for occupancy; pointers may be equal when full or empty.
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            count         <= '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (wr_accept) begin
                write_pointer <= (write_pointer == LAST_PTR) ? '0 : write_pointer + 1'b1;
            end
            if (rd_accept) begin
                read_pointer <= (read_pointer == LAST_PTR) ? '0 : read_pointer + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk_i     (clk),
        .rst_i     (reset),
        .wr_en_i   (wr_accept),
        .wr_addr_i (write_pointer),
        .wr_dat_i  (data_in),
        .rd_en_i   (rd_accept),
        .rd_addr_i (read_pointer),
        .rd_dat_o  (data_out)
    );

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int vectors;
    int miscompares;

    // Reference state
    logic [DW-1:0] sb [$];
    int            m_count;
    int            m_wp;
    int            m_rp;
    logic [DW-1:0] m_out;

    fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_wp    = 0;
        m_rp    = 0;
        m_out   = '0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(dut.count), 32'(m_count));
        check({tag, ".full"}, 32'(full), 32'(m_count == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
        check({tag, ".data_out"}, 32'(data_out), 32'(m_out));
        check({tag, ".wptr"}, 32'(dut.write_pointer), 32'(m_wp));
        check({tag, ".rptr"}, 32'(dut.read_pointer), 32'(m_rp));
    endtask

    // One clock with the given requests; reference updated from pre-edge occupancy.
    task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d, input string tag);
        bit wa;
        bit ra;
        wa      = wr && (m_count < DEPTH);
        ra      = rd && (m_count > 0);
        wr_en   = wr;
        rd_en   = rd;
        data_in = d;
        if (ra) begin
            m_out = sb.pop_front();
            m_rp  = (m_rp + 1) % DEPTH;
        end
        if (wa) begin
            sb.push_back(d);
            m_wp = (m_wp + 1) % DEPTH;
        end
        m_count = m_count + int'(wa) - int'(ra);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        data_in     = '0;
        reset       = 1'b1;
        model_reset();

        // Reset state, observed while reset is still asserted
        #15;
        check_state("reset");
        #5;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_state("post_reset");

        // Fill to full
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), "fill");
        check("fill.full_flag", 32'(full), 32'd1);

        // Overflow write is dropped
        cycle(1'b1, 1'b0, 8'h11, "overflow");
        check("overflow.wptr_zero", 32'(dut.write_pointer), 32'd0);

        // Drain in order
        for (int i = 1; i <= DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, "drain");
        check("drain.last_word", 32'(data_out), 32'h10);

        // Underflow read holds data_out
        cycle(1'b0, 1'b1, 8'h00, "underflow");
        check("underflow.hold", 32'(data_out), 32'h10);

        // Wrap-around: pointers travel past DEPTH-1 back to 0
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DW'(8'h20 + i), "wrap_w1");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, "wrap_r1");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DW'(8'h40 + i), "wrap_w2");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, "wrap_r2");
        check("wrap.rptr4", 32'(dut.read_pointer), 32'd4);
        check("wrap.wptr4", 32'(dut.write_pointer), 32'd4);

        // Simultaneous read/write while empty: write only, data_out holds
        cycle(1'b1, 1'b1, 8'hAA, "simul_empty");
        check("simul_empty.count1", 32'(dut.count), 32'd1);
        check("simul_empty.hold", 32'(data_out), 32'h49);

        // Simultaneous with 5 entries: count unchanged, oldest word out
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'(8'h60 + i), "to5");
        cycle(1'b1, 1'b1, 8'hAA, "simul_mid");
        check("simul_mid.count5", 32'(dut.count), 32'd5);
        check("simul_mid.oldest", 32'(data_out), 32'hAA);

        // Simultaneous while full: read only, new word dropped
        while (m_count < DEPTH) cycle(1'b1, 1'b0, DW'(8'h80 + m_count), "to_full");
        cycle(1'b1, 1'b1, 8'hAA, "simul_full");
        check("simul_full.count15", 32'(dut.count), 32'd15);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, 8'h00, "simul_full_drain");
        check("simul_full.empty", 32'(empty), 32'd1);

        // Mid-stream async reset with 7 entries queued
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'hC0 + i), "pre_rst_w");
        cycle(1'b0, 1'b1, 8'h00, "pre_rst_r");
        check("pre_rst.count7", 32'(dut.count), 32'd7);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_state("async_rst");
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'h5A, "after_rst_w");
        cycle(1'b0, 1'b1, 8'h00, "after_rst_r");
        check("after_rst.data", 32'(data_out), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
